preg_free_list: RTL

//  Physical-register free list for the rename stage: supplies a free p_reg for each renamed destination.

---
 rtl/preg_free_list_pkg.sv | 17 +
 rtl/preg_free_list.sv | 96 +++++++++
 2 files changed

// File: rtl/preg_free_list_pkg.sv
// Shared rename types: physical register index, free-list sizing
// and the free-list pointer helper used by preg_free_list.
package preg_free_list_pkg;

    localparam int NUM_PREGS  = 128;
    localparam int NUM_AREGS  = 32;
    localparam int FREE_DEPTH = NUM_PREGS - NUM_AREGS;

    typedef logic [6:0] p_reg;
    typedef logic [6:0] flPtr;

    // FREE_DEPTH is not a power of two, so the wrap is explicit.
    function automatic flPtr ptrInc(input flPtr p);
        return (p == flPtr'(FREE_DEPTH - 1)) ? '0 : p + 7'd1;
    endfunction

endpackage

// File: rtl/preg_free_list.sv
// Physical-register free list: rename pops free pregs at the head,
// retire pushes reclaimed pregs at the tail.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   alloc_req         rename wants one destination preg
//   alloc_valid       list non-empty, alloc_preg is usable
//   alloc_preg        head entry, show-ahead
//   release_valid     retire returns release_preg this cycle
//   release_preg      preg being freed
//   free_count        entries held, 0..FREE_DEPTH
//   overflow_err      sticky: release dropped, list full
//   double_free_err   sticky: release dropped, preg already free
module preg_free_list
    import preg_free_list_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       alloc_req,
    output logic       alloc_valid,
    output p_reg       alloc_preg,
    input  logic       release_valid,
    input  p_reg       release_preg,
    output logic [6:0] free_count,
    output logic       overflow_err,
    output logic       double_free_err
);

    p_reg                 mem [FREE_DEPTH];
    flPtr                 head;
    flPtr                 tail;
    logic [6:0]           count;
    logic [NUM_PREGS-1:0] freeMap;
    logic                 ovfErr;
    logic                 dblErr;

    logic allocFire;
    logic relLive;
    logic relIsFree;
    logic relFull;
    logic relAccept;
    logic relDouble;
    logic relOverflow;

    assign alloc_valid     = (count != '0);
    assign alloc_preg      = mem[head];
    assign free_count      = count;
    assign overflow_err    = ovfErr;
    assign double_free_err = dblErr;

    // Release checks use the pre-fire bitmap and count: a preg being
    // allocated this cycle is still free, and a full list stays full.
    always_comb begin
        allocFire   = alloc_req & alloc_valid;
        relLive     = release_valid & (release_preg != '0);
        relIsFree   = freeMap[release_preg];
        relFull     = (count == 7'(FREE_DEPTH));
        relAccept   = relLive & ~relIsFree & ~relFull;
        relDouble   = relLive & relIsFree;
        relOverflow = relLive & ~relIsFree & relFull;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FREE_DEPTH; i++) begin
                mem[i] <= p_reg'(NUM_AREGS + i);
            end
            head    <= '0;
            tail    <= '0;
            count   <= 7'(FREE_DEPTH);
            freeMap <= {{FREE_DEPTH{1'b1}}, {NUM_AREGS{1'b0}}};
            ovfErr  <= 1'b0;
            dblErr  <= 1'b0;
        end else begin
            if (allocFire) begin
                head                <= ptrInc(head);
                freeMap[alloc_preg] <= 1'b0;
            end
            // An accepted preg has a clear bit, so it never collides
            // with the head preg being cleared above.
            if (relAccept) begin
                mem[tail]             <= release_preg;
                tail                  <= ptrInc(tail);
                freeMap[release_preg] <= 1'b1;
            end
            unique case ({relAccept, allocFire})
                2'b10:   count <= count + 7'd1;
                2'b01:   count <= count - 7'd1;
                default: count <= count;
            endcase
            if (relOverflow) ovfErr <= 1'b1;
            if (relDouble)   dblErr <= 1'b1;
        end
    end

endmodule
